pseudo_spi_intf: RTL and testbench

PSEUDO_SPI_INTF -- requirements
Module: pseudo_spi_intf

---
 rtl/pseudo_spi_intf.sv | 163 ++++++++++++++++
 tb/tb_pseudo_spi_intf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pseudo_spi_intf.sv
`timescale 1ns/1ps
// pseudo_spi_intf: streams DATA_LEN bytes from a synchronous 512x8 SRAM,
// starting at ADDR_BGN+1, as an LSB-first serial stream with two
// non-overlapping serial clocks (SCLK1 in SOUT, SCLK2 in LOOP) and a
// one-cycle byte latch strobe (LAT in RDY).
// Optional feature macro: PSEUDO_SPI_FREQ_DIV_EN adds a FREQ_DIV input that
// stretches every SOUT and LOOP state to FREQ_DIV+1 cycles.
// Handshake: BGN is a level enable; it must stay high for the whole transfer.
// Dropping BGN in any state other than IDLE aborts back to IDLE, and
// spi_is_done stays high in DONE until BGN is released.
module pseudo_spi_intf (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BGN,
    input  logic [8:0] ADDR_BGN,
    input  logic [7:0] DATA_LEN,
    input  logic [7:0] PI,
`ifdef PSEUDO_SPI_FREQ_DIV_EN
    input  logic [7:0] FREQ_DIV,
`endif
    output logic       SCLK1,
    output logic       SCLK2,
    output logic       LAT,
    output logic       SPI_SO,
    output logic       CEN,
    output logic [8:0] A,
    output logic       D_WE,
    output logic       spi_is_done,
    output logic [2:0] o_spi_state
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        ADDR = 3'b001,
        READ = 3'b011,
        SOUT = 3'b010,
        LOOP = 3'b110,
        RDY  = 3'b100,
        DONE = 3'b101
    } spi_state_t;

    spi_state_t spi_state;
    spi_state_t w_next_state;

    logic       r_cen;
    logic [8:0] r_addr;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_read_wait;   // high in the second READ cycle
    logic       w_abort;
    logic       w_adv;         // SOUT/LOOP may advance this cycle

    assign w_abort = (spi_state != IDLE) && !BGN;

`ifdef PSEUDO_SPI_FREQ_DIV_EN
    logic [7:0] r_freq_div;
    logic [7:0] r_div_cnt;

    assign w_adv = (r_div_cnt == r_freq_div);

    // Divider: sample FREQ_DIV in IDLE, count cycles spent in SOUT/LOOP
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_freq_div <= 8'd0;
            r_div_cnt  <= 8'd0;
        end else begin
            if (spi_state == IDLE)
                r_freq_div <= FREQ_DIV;
            if ((spi_state == SOUT || spi_state == LOOP) && !w_adv && !w_abort)
                r_div_cnt <= r_div_cnt + 8'd1;
            else
                r_div_cnt <= 8'd0;
        end
    end
`else
    assign w_adv = 1'b1;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            spi_state <= IDLE;
        else
            spi_state <= w_next_state;
    end

    // Next-state decode; a dropped BGN overrides every other transition
    always_comb begin
        w_next_state = spi_state;
        if (w_abort) begin
            w_next_state = IDLE;
        end else begin
            case (spi_state)
                IDLE: if (BGN) w_next_state = (DATA_LEN == 8'd0) ? DONE : ADDR;
                ADDR: w_next_state = READ;
                READ: if (r_read_wait) w_next_state = SOUT;
                SOUT: if (w_adv) w_next_state = LOOP;
                LOOP: if (w_adv) w_next_state = (r_bit_cnt != 3'd7) ? SOUT : RDY;
                RDY:  w_next_state = (r_byte_cnt == 8'd1) ? DONE : ADDR;
                DONE: w_next_state = DONE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Datapath: address, chip enable, byte/bit counters and shift register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cen       <= 1'b1;
            r_addr      <= 9'd0;
            r_byte_cnt  <= 8'd0;
            r_shift     <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_read_wait <= 1'b0;
        end else begin
            r_read_wait <= (spi_state == READ) && !r_read_wait && !w_abort;
            if (w_abort) begin
                r_cen <= 1'b1;
            end else begin
                case (spi_state)
                    IDLE: begin
                        if (BGN) begin
                            r_addr     <= ADDR_BGN;
                            r_byte_cnt <= DATA_LEN;
                        end
                    end
                    ADDR: begin
                        r_addr <= r_addr + 9'd1;
                        r_cen  <= 1'b0;
                    end
                    READ: begin
                        // SRAM Q is valid in the second READ cycle
                        if (r_read_wait) begin
                            r_shift   <= PI;
                            r_bit_cnt <= 3'd0;
                            r_cen     <= 1'b1;
                        end
                    end
                    LOOP: begin
                        if (w_adv) begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    RDY: r_byte_cnt <= r_byte_cnt - 8'd1;
                    default: ;
                endcase
            end
        end
    end

    assign SCLK1       = (spi_state == SOUT);
    assign SCLK2       = (spi_state == LOOP);
    assign LAT         = (spi_state == RDY);
    assign spi_is_done = (spi_state == DONE);
    assign SPI_SO      = (spi_state == SOUT || spi_state == LOOP) && r_shift[0];
    assign CEN         = r_cen;
    assign A           = r_addr;
    assign D_WE        = 1'b1;
    assign o_spi_state = spi_state;

endmodule

// File: tb/tb_pseudo_spi_intf.sv
`timescale 1ns/1ps
module tb_pseudo_spi_intf;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ADDR = 3'b001;
  localparam logic [2:0] S_READ = 3'b011;
  localparam logic [2:0] S_SOUT = 3'b010;
  localparam logic [2:0] S_LOOP = 3'b110;
  localparam logic [2:0] S_DONE = 3'b101;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       bgn;
  logic [8:0] addr_bgn;
  logic [7:0] data_len;
  logic [7:0] pi;
  logic       sclk1, sclk2, lat, so, cen, d_we, done;
  logic [8:0] a;
  logic [2:0] st;

  always #5 clk = ~clk;

  pseudo_spi_intf dut (
    .CLK(clk), .RST(rst), .BGN(bgn), .ADDR_BGN(addr_bgn), .DATA_LEN(data_len),
    .PI(pi), .SCLK1(sclk1), .SCLK2(sclk2), .LAT(lat), .SPI_SO(so), .CEN(cen),
    .A(a), .D_WE(d_we), .spi_is_done(done), .o_spi_state(st)
  );

  // synchronous 512x8 SRAM model, read only
  logic [7:0] mem [0:511];
  always @(posedge clk) if (!cen) pi <= mem[a];

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [8:0] exp_a_q[$];
  int n_vec = 0;
  int n_err = 0;
  int lat_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expected address on each READ entry, expected byte after 8 LOOPs
  initial begin
    logic [2:0] prev_st;
    logic [7:0] sh;
    logic       so_sout;
    int bits, s1, s2;
    prev_st = S_IDLE; sh = 8'd0; so_sout = 1'b0; bits = 0; s1 = 0; s2 = 0;
    forever begin
      @(negedge clk);
      if (rst || st == S_IDLE || st == S_ADDR) begin
        bits = 0; s1 = 0; s2 = 0;
      end
      if (st == S_READ && prev_st == S_ADDR) begin
        if (exp_a_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL addr_unexpected act=%0d req=none", a);
        end else begin
          check("addr", 32'(a), 32'(exp_a_q.pop_front()));
        end
      end
      if (sclk1) begin
        s1++;
        so_sout = so;
      end
      if (sclk2) begin
        s2++;
        check("so_stable", 32'(so), 32'(so_sout));
        sh = {so, sh[7:1]};
        bits++;
        if (bits == 8) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL byte_unexpected act=%0h req=none", sh);
          end else begin
            check("byte", 32'(sh), 32'(exp_q.pop_front()));
          end
        end
      end
      if (lat) begin
        lat_total++;
        check("bits_per_byte", 32'(bits), 32'd8);
        check("sclk1_per_byte", 32'(s1), 32'd8);
        check("sclk2_per_byte", 32'(s2), 32'd8);
        check("d_we", 32'(d_we), 32'd1);
      end
      prev_st = st;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_run(input int start, input int len);
    logic [8:0] ad;
    for (int i = 0; i < len; i++) begin
      ad = 9'(start + 1 + i);
      exp_a_q.push_back(ad);
      exp_q.push_back(mem[ad]);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    exp_a_q.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic finish_run(input string name);
    check(name, 32'(exp_q.size() + exp_a_q.size()), 32'd0);
    bgn = 1'b0;
    tick(1);
    check("idle_after_done", 32'(st), 32'(S_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] tbl [0:13];
    int start, len;
    tbl = '{8'hAB, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h05, 8'h3D,
            8'h9E, 8'hC3, 8'hD7, 8'h58, 8'h7A, 8'h01, 8'hC2};
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 14; i++) mem[32 + i] = tbl[i];
    rst = 1'b1; bgn = 1'b0; addr_bgn = 9'd0; data_len = 8'd0;

    // reset values
    #12;
    check("rst_state", 32'(st), 32'(S_IDLE));
    check("rst_cen", 32'(cen), 32'd1);
    check("rst_a", 32'(a), 32'd0);
    check("rst_dwe", 32'(d_we), 32'd1);
    check("rst_sclk", 32'({sclk1, sclk2, lat}), 32'd0);
    check("rst_so_done", 32'({so, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // 14-byte stream from 32; mid-transfer changes to ADDR_BGN/DATA_LEN ignored
    lat_total = 0;
    addr_bgn = 9'd31; data_len = 8'd14;
    push_run(31, 14);
    bgn = 1'b1;
    tick(4);
    addr_bgn = 9'h100; data_len = 8'd3;
    wait_done("done_stream14", 14 * 20 + 20);
    check("lat_total_14", 32'(lat_total), 32'd14);
    finish_run("queue_stream14");

    // address wrap 511 -> 0
    mem[0] = 8'h5A;
    addr_bgn = 9'd511; data_len = 8'd1;
    push_run(511, 1);
    bgn = 1'b1;
    wait_done("done_wrap", 40);
    finish_run("queue_wrap");

    // zero length: straight to DONE, no SRAM access, no serial clocks
    data_len = 8'd0;
    bgn = 1'b1;
    tick(1);
    check("len0_state", 32'(st), 32'(S_DONE));
    for (int i = 0; i < 3; i++) begin
      check("len0_quiet", 32'({cen, sclk1, sclk2, lat}), 32'b1000);
      tick(1);
    end
    bgn = 1'b0;
    tick(1);
    check("len0_idle", 32'(st), 32'(S_IDLE));

    // abort during bit 2 of byte 2, then restart
    addr_bgn = 9'd31; data_len = 8'd14;
    push_run(31, 14);
    bgn = 1'b1;
    tick(28);
    check("abort_pre_state", 32'(st), 32'(S_SOUT));
    bgn = 1'b0;
    tick(1);
    check("abort_state", 32'(st), 32'(S_IDLE));
    check("abort_outs", 32'({cen, sclk1, sclk2, lat}), 32'b1000);
    check("abort_bytes_left", 32'(exp_q.size()), 32'd13);
    flush();
    tick(1);
    push_run(31, 14);
    bgn = 1'b1;
    wait_done("done_restart", 14 * 20 + 20);
    finish_run("queue_restart");

    // asynchronous reset while in READ
    flush();
    exp_a_q.push_back(9'd32);
    addr_bgn = 9'd31; data_len = 8'd14;
    bgn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_cen", 32'(cen), 32'd0);
    check("pre_rst_a", 32'(a), 32'd32);
    rst = 1'b1;
    bgn = 1'b0;
    #1;
    check("arst_state", 32'(st), 32'(S_IDLE));
    check("arst_cen_a", 32'({cen, a}), 32'({1'b1, 9'd0}));
    check("arst_outs", 32'({sclk1, sclk2, lat, so, done}), 32'd0);
    flush();
    @(negedge clk);
    rst = 1'b0;
    tick(3);
    check("post_rst_idle", 32'(st), 32'(S_IDLE));

    addr_bgn = 9'd40; data_len = 8'd2;
    push_run(40, 2);
    bgn = 1'b1;
    wait_done("done_after_rst", 60);
    finish_run("queue_after_rst");

    // short random transfers
    for (int k = 0; k < 2; k++) begin
      start = $urandom_range(100, 400);
      len = $urandom_range(1, 3);
      for (int i = 1; i <= len; i++) mem[start + i] = 8'($urandom_range(0, 255));
      addr_bgn = 9'(start); data_len = 8'(len);
      push_run(start, len);
      bgn = 1'b1;
      wait_done("done_rand", len * 20 + 20);
      finish_run("queue_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
